aes_inv_key_expand_128: RTL and testbench

- Decrypt-side companion to the forward AES-128 key expander.
- Takes either the cipher key or the final (round-10) round key. Emits the round keys in reverse order, round 10 down to round 0, one per accepted cycle, with a valid/ready handshake.
- Feeds the inverse cipher datapath (AddRoundKey in InvCipher order).
- One set of four aes_sbox instances is shared between the forward pre-walk and the inverse walk.

---
 rtl/aes_inv_key_expand_128.sv | 173 +++++++++++++++++
 tb/tb_aes_inv_key_expand_128.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_key_expand_128.sv
// AES-128 inverse key expander: walks forward from a cipher key (or takes the
// round-10 key directly), then emits round keys 10..0 over a valid/ready handshake.

module aes_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] s_o
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0 as the S-box needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = gf_mul(x, x);
        acc = sq;
        for (int i = 0; i < 6; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    logic [7:0] b;

    assign b   = gf_inv(a_i);
    assign s_o = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
               ^ {b[3:0], b[7:4]} ^ 8'h63;
endmodule

module aes_inv_key_expand_128 (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         key_is_last,
    input  logic [127:0] key,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [31:0]  wo_0,
    output logic [31:0]  wo_1,
    output logic [31:0]  wo_2,
    output logic [31:0]  wo_3,
    output logic [3:0]   rnd,
    output logic         busy,
    output logic         done
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        INV  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0][31:0] w_q, w_d;
    logic [3:0]       rnd_q, rnd_d;
    logic             done_q, done_d;

    logic [31:0] sub_in;
    logic [31:0] rot;
    logic [31:0] sub_out;
    logic [31:0] t;
    logic [3:0]  rcon_rnd;
    logic [7:0]  rcon;

    // Shared S-boxes: forward step needs w3, inverse step recovers old w3 as w3^w2.
    assign sub_in = (state_q == INV) ? (w_q[3] ^ w_q[2]) : w_q[3];
    assign rot    = {sub_in[23:0], sub_in[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .a_i (rot[8*i +: 8]),
            .s_o (sub_out[8*i +: 8])
        );
    end

    assign rcon_rnd = (state_q == FWD) ? (rnd_q + 4'd1) : rnd_q;

    always_comb begin
        case (rcon_rnd)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign t = sub_out ^ {rcon, 24'h000000};

    always_comb begin
        // NOTE: every next-state signal gets a hold default first so no path infers a latch.
        state_d = state_q;
        w_d     = w_q;
        rnd_d   = rnd_q;
        done_d  = 1'b0;

        case (state_q)
            FWD: begin
                w_d[0] = w_q[0] ^ t;
                w_d[1] = w_q[1] ^ w_d[0];
                w_d[2] = w_q[2] ^ w_d[1];
                w_d[3] = w_q[3] ^ w_d[2];
                rnd_d  = rnd_q + 4'd1;
                if (rnd_q == 4'd9) state_d = INV;
            end
            INV: begin
                if (out_ready) begin
                    if (rnd_q != 4'd0) begin
                        w_d[3] = w_q[3] ^ w_q[2];
                        w_d[2] = w_q[2] ^ w_q[1];
                        w_d[1] = w_q[1] ^ w_q[0];
                        w_d[0] = w_q[0] ^ t;
                        rnd_d  = rnd_q - 4'd1;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        // A new key overrides whatever the walk was doing, including a pending done.
        if (start) begin
            w_d[0]  = key[127:96];
            w_d[1]  = key[95:64];
            w_d[2]  = key[63:32];
            w_d[3]  = key[31:0];
            rnd_d   = key_is_last ? 4'd10 : 4'd0;
            state_d = key_is_last ? INV : FWD;
            done_d  = 1'b0;
        end
    end

    // NOTE: sequential state updates use non-blocking assignments so all registers sample together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            w_q     <= '0;
            rnd_q   <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            rnd_q   <= rnd_d;
            done_q  <= done_d;
        end
    end

    assign out_valid = (state_q == INV);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign rnd       = rnd_q;
    assign wo_0      = w_q[0];
    assign wo_1      = w_q[1];
    assign wo_2      = w_q[2];
    assign wo_3      = w_q[3];
endmodule

// File: tb/tb_aes_inv_key_expand_128.sv
// Bench for aes_inv_key_expand_128: table-based forward expansion model feeds a
// scoreboard of expected round keys, popped as the DUT transfers beats.

module tb_aes_inv_key_expand_128;
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         key_is_last;
    logic [127:0] key;
    logic         out_ready;
    logic         out_valid;
    logic [31:0]  wo_0, wo_1, wo_2, wo_3;
    logic [3:0]   rnd;
    logic         busy;
    logic         done;

    aes_inv_key_expand_128 dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .key_is_last (key_is_last),
        .key         (key),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .wo_0        (wo_0),
        .wo_1        (wo_1),
        .wo_2        (wo_2),
        .wo_3        (wo_3),
        .rnd         (rnd),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]   rnd;
        logic [127:0] w;
    } beat_t;

    beat_t        sb_q[$];
    logic [127:0] rk [11];
    int           total = 0;
    int           bad = 0;
    int           done_cnt = 0;

    logic [127:0] sbox_rows [16] = '{
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] ref_sb(input logic [7:0] b);
        logic [127:0] row;
        row = sbox_rows[b[7:4]];
        return row[8*(15 - int'(b[3:0])) +: 8];
    endfunction

    task automatic expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {ref_sb(tmp[23:16]), ref_sb(tmp[15:8]), ref_sb(tmp[7:0]), ref_sb(tmp[31:24])}
                    ^ {rc, 24'h000000};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_run();
        for (int r = 10; r >= 0; r--) sb_q.push_back('{rnd: 4'(r), w: rk[r]});
    endtask

    task automatic do_start(input logic [127:0] k, input logic last);
        start       = 1'b1;
        key_is_last = last;
        key         = k;
        done_cnt    = 0;
        step();
        start = 1'b0;
    endtask

    // Transfers beats until the scoreboard drains, the budget expires, or the DUT
    // presents stop_rnd. Optionally stalls once at stall_rnd or randomises ready.
    task automatic consume(input int budget, input int stop_rnd, input int stall_rnd,
                           input int stall_len, input bit rand_ready);
        beat_t exp;
        bit    stalled;
        stalled = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (sb_q.size() == 0) break;
            if (out_valid && stop_rnd >= 0 && int'(rnd) == stop_rnd) break;
            if (done) done_cnt++;
            if (out_valid && !stalled && int'(rnd) == stall_rnd) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    step();
                    check("stall_valid", 128'(out_valid), 128'd1);
                    check("stall_rnd", 128'(rnd), 128'(sb_q[0].rnd));
                    check("stall_words", {wo_0, wo_1, wo_2, wo_3}, sb_q[0].w);
                end
                out_ready = 1'b1;
                stalled   = 1'b1;
            end else if (rand_ready) begin
                out_ready = ($urandom_range(0, 3) != 0);
            end
            if (out_valid && out_ready) begin
                exp = sb_q.pop_front();
                check("beat_rnd", 128'(rnd), 128'(exp.rnd));
                check("beat_words", {wo_0, wo_1, wo_2, wo_3}, exp.w);
            end
            step();
        end
    endtask

    task automatic finish_run(input logic [127:0] k0);
        check("drained", 128'(sb_q.size()), 128'd0);
        check("no_early_done", 128'(done_cnt), 128'd0);
        check("done_pulse", 128'(done), 128'd1);
        out_ready = 1'b1;
        step();
        check("done_cleared", 128'(done), 128'd0);
        check("idle_busy", 128'(busy), 128'd0);
        check("idle_valid", 128'(out_valid), 128'd0);
        check("idle_rnd", 128'(rnd), 128'd0);
        check("idle_words", {wo_0, wo_1, wo_2, wo_3}, k0);
    endtask

    logic [127:0] ck1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    logic [127:0] ck2 = 128'h000102030405060708090a0b0c0d0e0f;
    logic [127:0] ck3 = 128'h00112233445566778899aabbccddeeff;

    initial begin
        rst = 1'b1; start = 1'b0; key_is_last = 1'b0; key = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 128'(out_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_rnd", 128'(rnd), 128'd0);
        check("rst_words", {wo_0, wo_1, wo_2, wo_3}, 128'd0);
        rst = 1'b0;
        step();

        // Cipher key with ready high: first valid exactly 10 edges after the start edge.
        expand(ck1);
        do_start(ck1, 1'b0);
        push_run();
        check("fwd_busy", 128'(busy), 128'd1);
        check("fwd_valid", 128'(out_valid), 128'd0);
        repeat (9) step();
        check("fwd_valid_late", 128'(out_valid), 128'd0);
        step();
        check("first_valid", 128'(out_valid), 128'd1);
        check("first_rnd", 128'(rnd), 128'd10);
        check("r10_literal", {wo_0, wo_1, wo_2, wo_3}, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        consume(200, 1, -1, 0, 1'b0);
        check("r1_literal", {wo_0, wo_1, wo_2, wo_3}, 128'ha0fafe1788542cb123a339392a6c7605);
        consume(200, -1, -1, 0, 1'b0);
        finish_run(ck1);

        // Round-10 key loaded directly.
        do_start(128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1);
        push_run();
        check("direct_valid", 128'(out_valid), 128'd1);
        check("direct_rnd", 128'(rnd), 128'd10);
        consume(200, -1, -1, 0, 1'b0);
        finish_run(ck1);

        // Backpressure at round 7 for five cycles.
        do_start(rk[10], 1'b1);
        push_run();
        consume(200, -1, 7, 5, 1'b0);
        finish_run(ck1);

        // Restart mid-forward walk with a round-10 key of another cipher key.
        do_start(ck1, 1'b0);
        repeat (4) step();
        check("midfwd_rnd", 128'(rnd), 128'd4);
        expand(ck2);
        do_start(rk[10], 1'b1);
        check("restart_fwd_done", 128'(done), 128'd0);
        push_run();
        consume(200, -1, -1, 0, 1'b0);
        finish_run(ck2);

        // Restart mid-inverse walk while the rnd=3 beat is being accepted.
        do_start(rk[10], 1'b1);
        push_run();
        consume(200, 3, -1, 0, 1'b0);
        check("midinv_rnd", 128'(rnd), 128'd3);
        sb_q.delete();
        expand(ck3);
        out_ready = 1'b1;
        do_start(ck3, 1'b0);
        check("restart_inv_done", 128'(done), 128'd0);
        check("restart_inv_rnd", 128'(rnd), 128'd0);
        check("restart_inv_valid", 128'(out_valid), 128'd0);
        push_run();
        consume(200, -1, -1, 0, 1'b0);
        finish_run(ck3);

        // Asynchronous reset in the middle of a cycle while in INV.
        do_start(rk[10], 1'b1);
        out_ready = 1'b0;
        repeat (2) step();
        #2;
        rst = 1'b1;
        #1;
        check("async_valid", 128'(out_valid), 128'd0);
        check("async_busy", 128'(busy), 128'd0);
        check("async_rnd", 128'(rnd), 128'd0);
        check("async_words", {wo_0, wo_1, wo_2, wo_3}, 128'd0);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        step();

        // Random cipher keys, either entry point, random backpressure.
        for (int n = 0; n < 100; n++) begin
            logic [127:0] ck;
            logic         last;
            ck   = {$urandom, $urandom, $urandom, $urandom};
            last = 1'($urandom_range(0, 1));
            expand(ck);
            do_start(last ? rk[10] : ck, last);
            push_run();
            consume(400, -1, -1, 0, 1'b1);
            finish_run(ck);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
